alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Execution sequencer wrapped around the 4-bit ALU. Accepts one micro-op at a time over a valid/ready handshake and drives the ALU control and operand inputs (a, b, s, m, crin). It consumes f and crout, then writes back to a 4-bit accumulator, a small register file and a carry flag. It is the stage directly upstream and downstream of the ALU in the 4-bit datapath.

Parameters:
NREGS, 4, register-file depth in nibbles; power of 2, range 2..16; register index = low log2(NREGS) bits of op_arg.

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous active-low reset
op_valid  in  1  micro-op present
op_ready  out  1  sequencer can accept a micro-op
op_code  in  4  micro-op opcode (table below)
op_arg  in  4  immediate value or register index
done  out  1  one-cycle pulse: write-back completed
err  out  1  one-cycle pulse, coincident with done: illegal opcode executed
alu_a  out  4  to ALU a
alu_b  out  4  to ALU b
alu_s  out  4  to ALU s
alu_m  out  1  to ALU m
alu_crin  out  1  to ALU crin
alu_f  in  4  from ALU f
alu_crout  in  1  from ALU crout
acc  out  4  accumulator
carry  out  1  carry flag
zero  out  1  acc == 0, combinational from acc
mismatch  out  1  self-check flag (see Optional Feature)

Behaviour:
- States: IDLE, EXEC. op_ready = (state == IDLE). Handshake fires on op_valid && op_ready at edge N. op_code/op_arg are latched and the state goes to EXEC.
- EXEC (cycle N+1): ALU inputs are driven from the latched op. At edge N+2, write-back is taken from alu_f/alu_crout and the state returns to IDLE. done=1 during cycle N+2. Throughput is 1 op per 2 cycles. op_valid asserted in the done cycle is accepted.
- In IDLE, all alu_* outputs = 0.
- Opcodes, listed as ALU drive followed by write-back. In each entry a = ALU a input, b = ALU b input, R[r] = register file entry at index r:
  0 NOP: ALU idle; no write-back.
  1 LDI: s=0, m=0, a=op_arg, crin=0; acc<=f.
  2 ADD r: s=9, m=0, a=acc, b=R[r], crin=0; acc<=f, carry<=crout.
  3 ADC r: as ADD but crin=carry.
  4 SUB r: s=6, m=0, a=acc, b=R[r], crin=1; acc<=f, carry<=crout (1 = no borrow).
  5 SBC r: as SUB but crin=carry.
  6 NOR r: s=1, m=1, a=acc, b=R[r]; acc<=f; carry unchanged.
  7 LD r: s=0xA, m=1, b=R[r]; acc<=f.
  8 ST r: s=0, m=0, a=acc, crin=0; R[r]<=f; acc unchanged.
  9 INC: s=0, m=0, a=acc, crin=1; acc<=f, carry<=crout.
  10..15: executed as NOP, with err=1 together with done.
- Unused alu_* fields are driven 0 in EXEC. crin is sampled from carry as held at the start of EXEC.
- Wrap-around: 4-bit results wrap modulo 16 and the carry-out goes to carry. Example: INC with acc=0xF gives acc=0, carry=1.
- Register index is op_arg modulo NREGS; upper bits are ignored.
- Reset (rst_n=0 at any edge, including mid-EXEC):
  - state <= IDLE, and the pending write-back is discarded.
  - acc, carry, all R[] <= 0; done, err, mismatch <= 0.
  - Hence zero=1 and op_ready=1 in the first cycle after reset release.
- op_valid while op_ready=0 is ignored. The upstream must hold op_code/op_arg stable until accepted.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined: an internal reference model computes the expected {crout, f} for the latched op in EXEC. This covers opcodes 1–9; NOR/LD/ST compare f only. On a mismatch at the write-back edge, mismatch is set and stays 1 until reset. Write-back still uses the ALU values.
- Undefined: no model is instantiated and mismatch is tied to 0.

Test Plan:
- Reset then idle → acc=0, carry=0, zero=1, op_ready=1, alu_* all 0.
- LDI 7; ST 1; LDI 9; ADD 1 → acc=0, carry=1, done each 2 cycles, op_ready low in EXEC cycles.
- LDI 3; ST 0; LDI 2; SUB 0 → acc=0xF, carry=0; then SBC 0 with R0=3 → acc=0xB, carry=1.
- LDI 0xF; INC → acc=0, carry=1, zero=1; NOR 0 with R0=0 → acc=0xF, carry still 1.
- op_code=0xC → done=1 and err=1 in the same cycle, acc/carry unchanged; op_valid held high during EXEC is not double-accepted.
- rst_n low during EXEC of ADD → no write-back, all state 0. With ALU_SEQ_CHECK_EN and ALU f forced to 0 on LDI 5 → mismatch=1 sticky.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- execution sequencer wrapped around the 4-bit ALU.
//
// Accepts one micro-op at a time over a valid/ready handshake. It drives the
// ALU operand and control inputs for one cycle (EXEC). On the following edge it
// writes f/crout back into the accumulator, the register file or the carry flag.
// Throughput is one micro-op every two cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   op_valid/op_ready   micro-op handshake
//   op_code, op_arg     micro-op opcode and immediate / register index
//   done, err           one-cycle write-back pulse; err flags an illegal opcode
//   alu_a/b/s/m/crin    drive to the ALU (all zero while idle)
//   alu_f, alu_crout    result from the ALU
//   acc, carry, zero    accumulator, carry flag, acc == 0
//   mismatch            sticky self-check flag
//
// Optional feature: define ALU_SEQ_CHECK_EN to build an internal reference
// model. The model compares the ALU result against the expected value at every
// write-back. When the macro is undefined, mismatch is tied to 0.
module alu_seq #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_code,
  input  logic [3:0] op_arg,
  output logic       done,
  output logic       err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_s,
  output logic       alu_m,
  output logic       alu_crin,
  input  logic [3:0] alu_f,
  input  logic       alu_crout,
  output logic [3:0] acc,
  output logic       carry,
  output logic       zero,
  output logic       mismatch
);

  localparam int IW = $clog2(NREGS);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SBC = 4'd5;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_LD  = 4'd7;
  localparam logic [3:0] OP_ST  = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t          state;
  logic [3:0]      code_p0;
  logic [IW-1:0]   ridx_p0;
  logic [3:0]      regs [NREGS];

  logic [3:0]      nxt_a;
  logic [3:0]      nxt_b;
  logic [3:0]      nxt_s;
  logic            nxt_m;
  logic            nxt_crin;
  logic [3:0]      rsel;

  assign op_ready = (state == IDLE);
  assign zero     = (acc == 4'd0);

  // ALU drive for the op being accepted. acc/carry/regs already hold any
  // write-back from the previous op, so registering this at the accept edge
  // equals driving from the latched op at the start of EXEC.
  always_comb begin
    nxt_a    = 4'd0;
    nxt_b    = 4'd0;
    nxt_s    = 4'd0;
    nxt_m    = 1'b0;
    nxt_crin = 1'b0;
    rsel     = regs[op_arg[IW-1:0]];
    case (op_code)
      OP_LDI: nxt_a = op_arg;
      OP_ADD, OP_ADC: begin
        nxt_s    = 4'h9;
        nxt_a    = acc;
        nxt_b    = rsel;
        nxt_crin = (op_code == OP_ADC) ? carry : 1'b0;
      end
      OP_SUB, OP_SBC: begin
        nxt_s    = 4'h6;
        nxt_a    = acc;
        nxt_b    = rsel;
        nxt_crin = (op_code == OP_SBC) ? carry : 1'b1;
      end
      OP_NOR: begin
        nxt_s = 4'h1;
        nxt_m = 1'b1;
        nxt_a = acc;
        nxt_b = rsel;
      end
      OP_LD: begin
        nxt_s = 4'hA;
        nxt_m = 1'b1;
        nxt_b = rsel;
      end
      OP_ST:  nxt_a = acc;
      OP_INC: begin
        nxt_a    = acc;
        nxt_crin = 1'b1;
      end
      default: ;
    endcase
  end

  // Data-side op latch (no reset needed: only read while in EXEC)
  always_ff @(posedge clk) begin
    if (op_valid && op_ready) begin
      code_p0 <= op_code;
      ridx_p0 <= op_arg[IW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= 4'd0;
      carry    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      alu_s    <= 4'd0;
      alu_m    <= 1'b0;
      alu_crin <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        // ---- accept stage: latch op, register ALU drive ----
        IDLE: begin
          if (op_valid) begin
            state    <= EXEC;
            alu_a    <= nxt_a;
            alu_b    <= nxt_b;
            alu_s    <= nxt_s;
            alu_m    <= nxt_m;
            alu_crin <= nxt_crin;
          end
        end
        // ---- write-back stage: consume f/crout, return to idle ----
        EXEC: begin
          state    <= IDLE;
          done     <= 1'b1;
          err      <= (code_p0 > OP_INC);
          alu_a    <= 4'd0;
          alu_b    <= 4'd0;
          alu_s    <= 4'd0;
          alu_m    <= 1'b0;
          alu_crin <= 1'b0;
          case (code_p0)
            OP_LDI, OP_NOR, OP_LD: acc <= alu_f;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC: begin
              acc   <= alu_f;
              carry <= alu_crout;
            end
            OP_ST:   regs[ridx_p0] <= alu_f;
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [3:0] arg_p0;
  logic [4:0] exp_cf;
  logic       cmp_c;
  logic       chk_hit;

  // Expected {crout, f} of the ALU for one micro-op
  function automatic logic [4:0] ref_alu(input logic [3:0] code,
                                         input logic [3:0] arg,
                                         input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic       cin);
    logic [4:0] r;
    r = 5'd0;
    case (code)
      OP_LDI:         r = {1'b0, arg};
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      OP_ADC:         r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      OP_SUB:         r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      OP_SBC:         r = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
      OP_NOR:         r = {1'b0, ~(a | b)};
      OP_LD:          r = {1'b0, b};
      OP_ST:          r = {1'b0, a};
      OP_INC:         r = {1'b0, a} + 5'd1;
      default:        r = 5'd0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (op_valid && op_ready) arg_p0 <= op_arg;
  end

  // acc, carry and regs are stable throughout EXEC, so the model reads them live
  always_comb begin
    exp_cf  = ref_alu(code_p0, arg_p0, acc, regs[ridx_p0], carry);
    cmp_c   = !((code_p0 == OP_NOR) || (code_p0 == OP_LD) || (code_p0 == OP_ST));
    chk_hit = (state == EXEC) && (code_p0 != OP_NOP) && (code_p0 <= OP_INC) &&
              ((alu_f != exp_cf[3:0]) || (cmp_c && (alu_crout != exp_cf[4])));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       mismatch <= 1'b0;
    else if (chk_hit) mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed bench for alu_seq. A behavioural 4-bit ALU closes the
// loop around the sequencer. Expected values are hand-computed constants.
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [3:0] op_arg;
  logic       done;
  logic       err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_crin;
  logic [3:0] alu_f;
  logic       alu_crout;
  logic [3:0] acc;
  logic       carry;
  logic       zero;
  logic       mismatch;

  int checks   = 0;
  int failures = 0;
  logic force_zero = 1'b0;
  logic [4:0] sum;

  alu_seq #(.NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_arg(op_arg),
    .done(done), .err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_crin(alu_crin),
    .alu_f(alu_f), .alu_crout(alu_crout),
    .acc(acc), .carry(carry), .zero(zero), .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: only the function selects the sequencer uses
  always_comb begin
    sum = 5'd0;
    case ({alu_m, alu_s})
      5'h00: sum = {1'b0, alu_a} + {4'd0, alu_crin};
      5'h09: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_crin};
      5'h06: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_crin};
      5'h10: sum = {1'b0, ~alu_a};
      5'h11: sum = {1'b0, ~(alu_a | alu_b)};
      5'h1A: sum = {1'b0, alu_b};
      default: sum = 5'd0;
    endcase
    alu_f     = force_zero ? 4'd0 : sum[3:0];
    alu_crout = force_zero ? 1'b0 : sum[4];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an op, step into EXEC and withdraw op_valid
  task automatic start(input logic [3:0] code, input logic [3:0] arg, input string tag);
    op_valid = 1'b1;
    op_code  = code;
    op_arg   = arg;
    @(posedge clk); #1;
    chk({tag, "_ready_exec"}, {7'd0, op_ready}, 8'd0);
    op_valid = 1'b0;
  endtask

  // Step into the done cycle and check the pulses
  task automatic finish(input logic exp_err, input string tag);
    @(posedge clk); #1;
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_err"},  {7'd0, err},  {7'd0, exp_err});
  endtask

  task automatic do_op(input logic [3:0] code, input logic [3:0] arg, input string tag);
    start(code, arg, tag);
    finish(1'b0, tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op_code  = 4'd0;
    op_arg   = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_acc",   {4'd0, acc}, 8'h00);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    chk("rst_zero",  {7'd0, zero}, 8'h01);
    chk("rst_ready", {7'd0, op_ready}, 8'h01);
    chk("rst_alu",   {alu_a, alu_b}, 8'h00);
    chk("rst_alu2",  {2'd0, alu_s, alu_m, alu_crin}, 8'h00);
    chk("rst_done",  {6'd0, done, err}, 8'h00);
    @(posedge clk); #1;
    chk("idle_alu",  {alu_a, alu_s}, 8'h00);

    // 9 + 7 = 16 -> acc 0, carry 1
    do_op(4'd1, 4'd7, "ldi7");
    chk("ldi7_acc", {4'd0, acc}, 8'h07);
    do_op(4'd8, 4'd1, "st1");
    do_op(4'd1, 4'd9, "ldi9");
    start(4'd2, 4'd1, "add1");
    chk("add1_drive", {alu_a, alu_b}, 8'h97);
    chk("add1_ctl",   {2'd0, alu_s, alu_m, alu_crin}, {2'd0, 4'h9, 1'b0, 1'b0});
    finish(1'b0, "add1");
    chk("add1_acc",   {4'd0, acc}, 8'h00);
    chk("add1_carry", {7'd0, carry}, 8'h01);
    chk("add1_zero",  {7'd0, zero}, 8'h01);
    chk("add1_ready", {7'd0, op_ready}, 8'h01);
    chk("add1_idle",  {alu_a, alu_b}, 8'h00);

    // 2 - 3 = 0xF with borrow; then F - 3 - 1 = 0xB, no borrow
    do_op(4'd1, 4'd3, "ldi3");
    do_op(4'd8, 4'd0, "st0");
    do_op(4'd1, 4'd2, "ldi2");
    do_op(4'd4, 4'd0, "sub0");
    chk("sub0_acc",   {4'd0, acc}, 8'h0F);
    chk("sub0_carry", {7'd0, carry}, 8'h00);
    start(4'd5, 4'd0, "sbc0");
    chk("sbc0_ctl", {2'd0, alu_s, alu_m, alu_crin}, {2'd0, 4'h6, 1'b0, 1'b0});
    finish(1'b0, "sbc0");
    chk("sbc0_acc",   {4'd0, acc}, 8'h0B);
    chk("sbc0_carry", {7'd0, carry}, 8'h01);

    // INC wrap F -> 0 with carry; NOR of zeros keeps carry
    do_op(4'd1, 4'hF, "ldiF");
    do_op(4'd9, 4'd0, "inc");
    chk("inc_acc",   {4'd0, acc}, 8'h00);
    chk("inc_carry", {7'd0, carry}, 8'h01);
    chk("inc_zero",  {7'd0, zero}, 8'h01);
    do_op(4'd8, 4'd0, "st0z");
    do_op(4'd6, 4'd0, "nor0");
    chk("nor0_acc",   {4'd0, acc}, 8'h0F);
    chk("nor0_carry", {7'd0, carry}, 8'h01);
    chk("nor0_zero",  {7'd0, zero}, 8'h00);

    // Illegal opcode with op_valid held through EXEC
    op_valid = 1'b1;
    op_code  = 4'hC;
    op_arg   = 4'd0;
    @(posedge clk); #1;
    chk("ill_ready_exec", {7'd0, op_ready}, 8'h00);
    @(posedge clk); #1;
    chk("ill_done_err", {6'd0, done, err}, 8'h03);
    chk("ill_acc",      {3'd0, carry, acc}, 8'h1F);
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk("ill_no_double", {6'd0, done, op_ready}, 8'h01);

    // Register index wraps modulo NREGS: LD 5 reads R1 = 7
    do_op(4'd7, 4'd5, "ld5");
    chk("ld5_acc", {4'd0, acc}, 8'h07);

    // Reset during EXEC of ADD discards write-back and clears all state
    start(4'd2, 4'd1, "addrst");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstx_state", {3'd0, acc, carry}, 8'h00);
    chk("rstx_flags", {5'd0, done, op_ready, zero}, 8'h03);
    do_op(4'd7, 4'd1, "ld1");
    chk("rstx_reg1", {4'd0, acc}, 8'h00);

    // ALU result forced to 0 during LDI 5
    chk("mm_pre", {7'd0, mismatch}, 8'h00);
    force_zero = 1'b1;
    do_op(4'd1, 4'd5, "ldi5bad");
    force_zero = 1'b0;
    chk("mm_acc", {4'd0, acc}, 8'h00);
`ifdef ALU_SEQ_CHECK_EN
    chk("mm_set", {7'd0, mismatch}, 8'h01);
    do_op(4'd1, 4'd1, "ldi1");
    chk("mm_sticky", {7'd0, mismatch}, 8'h01);
`else
    chk("mm_off", {7'd0, mismatch}, 8'h00);
    do_op(4'd1, 4'd1, "ldi1");
    chk("mm_off2", {7'd0, mismatch}, 8'h00);
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mm_clr", {7'd0, mismatch}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
